// File: rtl/divider_pkg.sv
// Shared widths, constants and state encoding for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned DW           = 8;
  localparam int unsigned VW           = 4;
  localparam int unsigned ITERATIONS   = 8;
  localparam int unsigned CNT_W        = $clog2(ITERATIONS);
  localparam logic [DW-1:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the switch/key front end and the divider.
interface seq_divider_if;
  import divider_pkg::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          dbz;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, dbz, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, dbz, quotient, remainder
  );

endinterface

// File: rtl/seq_divider_trial_subtract.sv
// Combinational trial subtraction: 5-bit partial remainder minus 4-bit divisor.
module trial_subtract
  import divider_pkg::*;
(
  input  logic [VW:0]   minuend,
  input  logic [VW-1:0] subtrahend,
  output logic [VW-1:0] diff,
  output logic          ge
);

  logic [VW:0] carry;

  // Ripple adder on the inverted divisor with carry-in 1. The top stage adds
  // the implicit inverted zero bit, so only its carry is needed: whenever ge
  // is set the difference fits in VW bits.
  always_comb begin
    carry    = '0;
    diff     = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < VW; i++) begin
      diff[i]      = minuend[i] ^ ~subtrahend[i] ^ carry[i];
      carry[i + 1] = (minuend[i] & ~subtrahend[i]) |
                     (carry[i] & (minuend[i] ^ ~subtrahend[i]));
    end
    ge = minuend[VW] | carry[VW];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, 8-bit dividend by 4-bit divisor,
// one quotient bit per clock, MSB first.
module seq_divider
  import divider_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  seq_divider_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [DW-1:0]    work;
  logic [VW-1:0]    dvs;
  logic [VW-1:0]    p;
  logic [VW:0]      p_shift;
  logic [VW-1:0]    diff;
  logic             ge;
  logic [VW-1:0]    p_next;
  logic [DW-1:0]    work_next;

  // work holds the unconsumed dividend bits at the top and the quotient bits
  // collected so far at the bottom; after the last step it is the quotient.
  assign p_shift   = {p, work[DW-1]};
  assign p_next    = ge ? diff : p_shift[VW-1:0];
  assign work_next = {work[DW-2:0], ge};

  trial_subtract u_trial (
    .minuend    (p_shift),
    .subtrahend (dvs),
    .diff       (diff),
    .ge         (ge)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      work          <= '0;
      dvs           <= '0;
      p             <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.dbz       <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              dvs      <= bus.divisor;
              work     <= bus.dividend;
              p        <= '0;
              count    <= '0;
              bus.busy <= 1'b1;
              bus.dbz  <= 1'b0;
              state    <= RUN;
            end else begin
              bus.dbz       <= 1'b1;
              bus.quotient  <= DBZ_QUOTIENT;
              bus.remainder <= '0;
              bus.done      <= 1'b1;
              state         <= DONE;
            end
          end
        end
        RUN: begin
          work  <= work_next;
          p     <= p_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITERATIONS - 1)) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= work_next;
            bus.remainder <= p_next;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed self-checking bench for seq_divider.
module tb_seq_divider;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  localparam int LAT_RUN = 8;   // edges from accept edge to done
  localparam int LAT_DBZ = 0;   // done visible right after the accept edge

  seq_divider_if bus ();

  seq_divider dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [3:0] b);
    return (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
  endfunction

  function automatic logic [3:0] ref_r(input logic [7:0] a, input logic [3:0] b);
    return (b == 0) ? 4'h0 : 4'(int'(a) % int'(b));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Waits for the block to be idle, then presents one start for one edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    for (int i = 0; i < 30 && (bus.busy || bus.done); i++) step();
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  // Returns edges after the accept edge until done is seen, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (bus.done) begin
        lat = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.dividend = 8'd5;
    bus.divisor  = 4'd1;
    step();
    step();
    checks++;
    if ({bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder});
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat;
    launch(8'd200, 4'd7);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b required 1", bus.busy);
    end
    wait_done(lat);
    checks++;
    if (lat != LAT_RUN || bus.quotient !== 8'd28 || bus.remainder !== 4'd4 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL basic_200_7: got lat=%0d q=%0d r=%0d dbz=%b required lat=%0d q=28 r=4 dbz=0",
               lat, bus.quotient, bus.remainder, bus.dbz, LAT_RUN);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] as [3] = '{8'd225, 8'd255, 8'd0};
    logic [3:0] bs [3] = '{4'd15, 4'd1, 4'd5};
    int lat;
    for (int n = 0; n < 3; n++) begin
      launch(as[n], bs[n]);
      wait_done(lat);
      checks++;
      if (lat != LAT_RUN || bus.quotient !== ref_q(as[n], bs[n]) || bus.remainder !== ref_r(as[n], bs[n])) begin
        errors++;
        $display("FAIL seq_%0d_%0d: got lat=%0d q=%0d r=%0d required lat=%0d q=%0d r=%0d",
                 as[n], bs[n], lat, bus.quotient, bus.remainder, LAT_RUN,
                 ref_q(as[n], bs[n]), ref_r(as[n], bs[n]));
      end
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (bus.quotient !== ref_q(as[n], bs[n]) || bus.remainder !== ref_r(as[n], bs[n])) begin
        errors++;
        $display("FAIL seq_hold_%0d: got q=%0d r=%0d required q=%0d r=%0d", n,
                 bus.quotient, bus.remainder, ref_q(as[n], bs[n]), ref_r(as[n], bs[n]));
      end
    end
  endtask

  task automatic test_dbz();
    int lat;
    launch(8'd13, 4'd0);
    wait_done(lat);
    checks++;
    if (lat != LAT_DBZ || bus.dbz !== 1'b1 || bus.quotient !== 8'hFF || bus.remainder !== 4'd0) begin
      errors++;
      $display("FAIL dbz_13_0: got lat=%0d dbz=%b q=%h r=%0d required lat=%0d dbz=1 q=ff r=0",
               lat, bus.dbz, bus.quotient, bus.remainder, LAT_DBZ);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL dbz_pulse: got done=%b required 0", bus.done);
    end
    launch(8'd9, 4'd3);
    checks++;
    if (bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear_on_start: got dbz=%b required 0", bus.dbz);
    end
    wait_done(lat);
    checks++;
    if (lat != LAT_RUN || bus.quotient !== 8'd3 || bus.remainder !== 4'd0 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL dbz_then_9_3: got lat=%0d q=%0d r=%0d dbz=%b required lat=%0d q=3 r=0 dbz=0",
               lat, bus.quotient, bus.remainder, bus.dbz, LAT_RUN);
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int first = -1;
    launch(8'd100, 4'd9);
    for (int c = 1; c <= 14; c++) begin
      // c is the number of edges since the accept edge
      bus.start    = (c == 3 || c == 8);
      bus.dividend = 8'd50;
      bus.divisor  = 4'd3;
      if (c == 3 || c == 8) begin
        bus.start = 1'b0;
      end
      if (c == 2 || c == 7) bus.start = 1'b1;
      step();
      if (bus.done) begin
        dones++;
        if (first < 0) begin
          first = c;
          checks++;
          if (bus.quotient !== 8'd11 || bus.remainder !== 4'd1) begin
            errors++;
            $display("FAIL ignored_result: got q=%0d r=%0d required q=11 r=1",
                     bus.quotient, bus.remainder);
          end
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 1 || first != LAT_RUN) begin
      errors++;
      $display("FAIL ignored_pulses: got dones=%0d at=%0d required dones=1 at=%0d",
               dones, first, LAT_RUN);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    int lat;
    launch(8'd250, 4'd6);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got %h required 0",
               {bus.busy, bus.done, bus.dbz, bus.quotient, bus.remainder});
    end
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses required 0", dones);
    end
    launch(8'd250, 4'd6);
    wait_done(lat);
    checks++;
    if (lat != LAT_RUN || bus.quotient !== 8'd41 || bus.remainder !== 4'd4) begin
      errors++;
      $display("FAIL reset_then_250_6: got lat=%0d q=%0d r=%0d required lat=%0d q=41 r=4",
               lat, bus.quotient, bus.remainder, LAT_RUN);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int gap = 0;
    bus.dividend = 8'd77;
    bus.divisor  = 4'd5;
    for (int i = 0; i < 30 && (bus.busy || bus.done); i++) step();
    bus.start = 1'b1;
    for (int i = 0; i < 40 && dones < 2; i++) begin
      step();
      if (dones == 1) gap++;
      if (bus.done) begin
        dones++;
        checks++;
        if (bus.quotient !== 8'd15 || bus.remainder !== 4'd2) begin
          errors++;
          $display("FAIL b2b_result_%0d: got q=%0d r=%0d required q=15 r=2",
                   dones, bus.quotient, bus.remainder);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 2 || gap > 12) begin
      errors++;
      $display("FAIL b2b_retrigger: got dones=%0d gap=%0d required dones=2 gap<=12", dones, gap);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] a;
    logic [3:0] b;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = (n % 8 == 0) ? 4'd0 : 4'($urandom);
      launch(a, b);
      wait_done(lat);
      checks++;
      if (lat != ((b == 0) ? LAT_DBZ : LAT_RUN) || bus.quotient !== ref_q(a, b) ||
          bus.remainder !== ref_r(a, b) || bus.dbz !== (b == 0)) begin
        errors++;
        $display("FAIL rand_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                 a, b, lat, bus.quotient, bus.remainder, bus.dbz, ref_q(a, b), ref_r(a, b), b == 0);
      end
    end
  endtask

  task automatic test_sweep();
    int lat;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        launch(8'(a), 4'(b));
        wait_done(lat);
        checks++;
        if (lat != LAT_RUN || int'(bus.quotient) * b + int'(bus.remainder) != a ||
            int'(bus.remainder) >= b) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: got lat=%0d q=%0d r=%0d required q*d+r=%0d r<%0d",
                   a, b, lat, bus.quotient, bus.remainder, a, b);
        end
      end
    end
  endtask

  initial begin
    clock        = 1'b0;
    reset        = 1'b1;
    errors       = 0;
    checks       = 0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_sequence();
    test_dbz();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
